// File: rtl/sprite_line_writer.sv
// Renderer-side read-modify-write into the sprite line buffer: z-priority merge,
// collision-mask merge with same-x forwarding, and per-line collision accumulation.
module sprite_line_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [7:0]  pix_color,
  input  logic [1:0]  pix_z,
  input  logic [3:0]  pix_mask,
  output logic [9:0]  lb_rd_idx,
  input  logic [15:0] lb_rd_data,
  output logic [9:0]  lb_wr_idx,
  output logic [15:0] lb_wr_data,
  output logic        lb_wr_en,
  output logic        busy,
  output logic [3:0]  collision
);

  // Merge a new sprite pixel into an existing entry; the earlier sprite wins z ties.
  function automatic logic [15:0] merge_entry(input logic [15:0] e,
                                               input logic [7:0]  color,
                                               input logic [1:0]  z,
                                               input logic [3:0]  mask);
    logic [15:0] r;
    if (e[11:10] == 2'd0) begin
      r = {mask, z, 2'b00, color};
    end else if (z > e[11:10]) begin
      r = {e[15:12] | mask, z, 2'b00, color};
    end else begin
      r = {e[15:12] | mask, e[11:10], 2'b00, e[7:0]};
    end
    return r;
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic [9:0]  s1_x_q, s1_x_d;
  logic [7:0]  s1_color_q, s1_color_d;
  logic [1:0]  s1_z_q, s1_z_d;
  logic [3:0]  s1_mask_q, s1_mask_d;

  logic        s2_valid_q, s2_valid_d;
  logic [9:0]  s2_x_q, s2_x_d;
  logic [7:0]  s2_color_q, s2_color_d;
  logic [1:0]  s2_z_q, s2_z_d;
  logic [3:0]  s2_mask_q, s2_mask_d;

  logic        fwd_valid_q, fwd_valid_d;
  logic [9:0]  fwd_idx_q, fwd_idx_d;
  logic [15:0] fwd_data_q, fwd_data_d;

  logic [3:0]  accum_q, accum_d;
  logic [3:0]  collision_q, collision_d;

  logic        accept;
  logic [15:0] existing;
  logic [3:0]  s2_hit_bits;

  assign pix_ready = !line_start;
  assign accept    = pix_valid && pix_ready && (pix_color != 8'd0) && (pix_z != 2'd0);

  // S1: s1_x doubles as the read index and holds when the stage is empty.
  always_comb begin
    s1_valid_d = accept;
    s1_x_d     = s1_x_q;
    s1_color_d = s1_color_q;
    s1_z_d     = s1_z_q;
    s1_mask_d  = s1_mask_q;
    if (accept) begin
      s1_x_d     = pix_x;
      s1_color_d = pix_color;
      s1_z_d     = pix_z;
      s1_mask_d  = pix_mask;
    end
  end

  assign lb_rd_idx = s1_x_q;

  // S2: the read data arrives now; the previous cycle's write is not yet visible.
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_x_d     = s1_x_q;
    s2_color_d = s1_color_q;
    s2_z_d     = s1_z_q;
    s2_mask_d  = s1_mask_q;
  end

  assign existing = (fwd_valid_q && (fwd_idx_q == s2_x_q)) ? fwd_data_q : lb_rd_data;

  assign lb_wr_en   = s2_valid_q;
  assign lb_wr_idx  = s2_x_q;
  assign lb_wr_data = s2_valid_q ? merge_entry(existing, s2_color_q, s2_z_q, s2_mask_q)
                                 : 16'h0000;
  assign busy       = s1_valid_q | s2_valid_q;

  assign s2_hit_bits = (s2_valid_q && (existing[11:10] != 2'd0))
                       ? (existing[15:12] & s2_mask_q) : 4'h0;

  always_comb begin
    fwd_valid_d = lb_wr_en;
    fwd_idx_d   = lb_wr_idx;
    fwd_data_d  = lb_wr_data;
  end

  always_comb begin
    accum_d     = accum_q | s2_hit_bits;
    collision_d = collision_q;
    if (line_start) begin
      collision_d = accum_q | s2_hit_bits;
      accum_d     = 4'h0;
    end
  end

  assign collision = collision_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= 10'd0;
      s1_color_q  <= 8'd0;
      s1_z_q      <= 2'd0;
      s1_mask_q   <= 4'd0;
      s2_valid_q  <= 1'b0;
      s2_x_q      <= 10'd0;
      s2_color_q  <= 8'd0;
      s2_z_q      <= 2'd0;
      s2_mask_q   <= 4'd0;
      fwd_valid_q <= 1'b0;
      fwd_idx_q   <= 10'd0;
      fwd_data_q  <= 16'h0000;
      accum_q     <= 4'h0;
      collision_q <= 4'h0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_color_q  <= s1_color_d;
      s1_z_q      <= s1_z_d;
      s1_mask_q   <= s1_mask_d;
      s2_valid_q  <= s2_valid_d;
      s2_x_q      <= s2_x_d;
      s2_color_q  <= s2_color_d;
      s2_z_q      <= s2_z_d;
      s2_mask_q   <= s2_mask_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_idx_q   <= fwd_idx_d;
      fwd_data_q  <= fwd_data_d;
      accum_q     <= accum_d;
      collision_q <= collision_d;
    end
  end

endmodule
